// File: rtl/multicycle_control_if.sv
// rtl/multicycle_control_if.sv - control/datapath/memory signal bundle for multicycle_control
interface multicycle_control_if #(
  parameter int CNT_W = 32
);
  logic [6:0]       opcode;
  logic             zero;
  logic             mem_ready;
  logic             mem_req;
  logic             mem_we;
  logic             iord;
  logic             ir_write;
  logic             pc_write;
  logic             reg_write;
  logic             mem_to_reg;
  logic             alu_src_a;
  logic [1:0]       alu_src_b;
  logic [1:0]       alu_op;
  logic             instr_done;
  logic [CNT_W-1:0] instret;
  logic             illegal;

  modport master (
    input  opcode, zero, mem_ready,
    output mem_req, mem_we, iord, ir_write, pc_write, reg_write, mem_to_reg,
           alu_src_a, alu_src_b, alu_op, instr_done, instret, illegal
  );

  modport slave (
    output opcode, zero, mem_ready,
    input  mem_req, mem_we, iord, ir_write, pc_write, reg_write, mem_to_reg,
           alu_src_a, alu_src_b, alu_op, instr_done, instret, illegal
  );
endinterface

// File: rtl/multicycle_control.sv
// rtl/multicycle_control.sv - multi-cycle RV32I-subset main controller; MULTICYCLE_CTRL_ILLEGAL_TRAP_EN enables HALT on unknown opcodes
module multicycle_control #(
  parameter int CNT_W = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  multicycle_control_if.master bus
);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC_R,
    S_EXEC_I,
    S_WB_ALU,
    S_MEM_ADDR,
    S_MEM_RD,
    S_WB_MEM,
    S_MEM_WR,
    S_BRANCH,
    S_HALT
  } state_t;

  state_t           state;
  logic             is_store;
  logic [CNT_W-1:0] instret_q;
  logic             retire;

  // Retire points: both writebacks, the store completion and the branch cycle.
  assign retire = (state == S_WB_ALU) || (state == S_WB_MEM) || (state == S_BRANCH) ||
                  ((state == S_MEM_WR) && bus.mem_ready);

`ifdef MULTICYCLE_CTRL_ILLEGAL_TRAP_EN
  logic illegal_q;
  assign bus.illegal = illegal_q;
`else
  assign bus.illegal = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_FETCH;
      is_store  <= 1'b0;
      instret_q <= '0;
`ifdef MULTICYCLE_CTRL_ILLEGAL_TRAP_EN
      illegal_q <= 1'b0;
`endif
    end else begin
      if (retire) begin
        instret_q <= instret_q + 1'b1;
      end
      case (state)
        S_FETCH:    if (bus.mem_ready) state <= S_DECODE;
        S_DECODE: begin
          // Load/store direction is captured here since opcode is only trusted in DECODE.
          is_store <= (bus.opcode == OP_STORE);
          case (bus.opcode)
            OP_R:               state <= S_EXEC_R;
            OP_I:               state <= S_EXEC_I;
            OP_LOAD, OP_STORE:  state <= S_MEM_ADDR;
            OP_BRANCH:          state <= S_BRANCH;
            default: begin
`ifdef MULTICYCLE_CTRL_ILLEGAL_TRAP_EN
              state     <= S_HALT;
              illegal_q <= 1'b1;
`else
              state     <= S_FETCH;
`endif
            end
          endcase
        end
        S_EXEC_R:   state <= S_WB_ALU;
        S_EXEC_I:   state <= S_WB_ALU;
        S_WB_ALU:   state <= S_FETCH;
        S_MEM_ADDR: state <= is_store ? S_MEM_WR : S_MEM_RD;
        S_MEM_RD:   if (bus.mem_ready) state <= S_WB_MEM;
        S_WB_MEM:   state <= S_FETCH;
        S_MEM_WR:   if (bus.mem_ready) state <= S_FETCH;
        S_BRANCH:   state <= S_FETCH;
        S_HALT:     state <= S_HALT;
        default:    state <= S_FETCH;
      endcase
    end
  end

  // Outputs decode from the state so an asynchronous reset reaches them at once.
  always_comb begin
    bus.mem_req    = 1'b0;
    bus.mem_we     = 1'b0;
    bus.iord       = 1'b0;
    bus.ir_write   = 1'b0;
    bus.pc_write   = 1'b0;
    bus.reg_write  = 1'b0;
    bus.mem_to_reg = 1'b0;
    bus.alu_src_a  = 1'b0;
    bus.alu_src_b  = 2'b00;
    bus.alu_op     = 2'b00;
    case (state)
      S_FETCH: begin
        bus.mem_req   = 1'b1;
        bus.alu_src_b = 2'b01;
        bus.ir_write  = bus.mem_ready;
        bus.pc_write  = bus.mem_ready;
      end
      S_DECODE: begin
        bus.alu_src_b = 2'b11;
      end
      S_EXEC_R: begin
        bus.alu_src_a = 1'b1;
        bus.alu_op    = 2'b10;
      end
      S_EXEC_I: begin
        bus.alu_src_a = 1'b1;
        bus.alu_src_b = 2'b11;
        bus.alu_op    = 2'b10;
      end
      S_WB_ALU: begin
        bus.reg_write = 1'b1;
      end
      S_MEM_ADDR: begin
        bus.alu_src_a = 1'b1;
        bus.alu_src_b = 2'b11;
      end
      S_MEM_RD: begin
        bus.mem_req = 1'b1;
        bus.iord    = 1'b1;
      end
      S_WB_MEM: begin
        bus.reg_write  = 1'b1;
        bus.mem_to_reg = 1'b1;
      end
      S_MEM_WR: begin
        bus.mem_req = 1'b1;
        bus.iord    = 1'b1;
        bus.mem_we  = 1'b1;
      end
      S_BRANCH: begin
        bus.alu_src_a = 1'b1;
        bus.alu_op    = 2'b01;
        bus.pc_write  = ~bus.zero;
      end
      default: ;
    endcase
  end

  assign bus.instr_done = retire;
  assign bus.instret    = instret_q;

endmodule

// File: tb/tb_multicycle_control.sv
// tb/tb_multicycle_control.sv - scoreboard bench for multicycle_control
module tb_multicycle_control;

  localparam int CNT_W = 4;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_BAD    = 7'b1111111;

  logic clk;
  logic rst_n;
  int   errors = 0;
  int   checks = 0;
  logic [CNT_W-1:0] exp_cnt = '0;
  logic [CNT_W-1:0] sb[$];

  multicycle_control_if #(.CNT_W(CNT_W)) bus ();

  multicycle_control #(.CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Retire monitor: each instr_done pops the counter value expected after that edge.
  always @(negedge clk) begin
    if (rst_n && bus.instr_done) begin
      if (sb.size() == 0) begin
        chk("unexpected_retire", 1, 0);
      end else begin
        logic [CNT_W-1:0] e;
        e = sb.pop_front();
        @(posedge clk);
        #1;
        chk("instret", 32'(bus.instret), 32'(e));
      end
    end
  end

  task automatic run_instr(input string tag, input logic [6:0] op, input int fw, input int mw,
                           input logic z, input int cyc, input bit ret, input int exp_pcw,
                           input logic [3:0] exp_mask, input bit exp_mtr, input int exp_rw,
                           input bit exp_back);
    int fcnt = 0, mcnt = 0, pcw = 0, irw = 0, rw = 0;
    logic mtr = 1'b0, back, in_dec = 1'b0;
    logic [3:0] mask = '0;
    if (ret) begin
      exp_cnt = exp_cnt + 1'b1;
      sb.push_back(exp_cnt);
    end
    bus.zero = z;
    for (int c = 0; c < cyc; c++) begin
      // Opcode is only meaningful in DECODE; scramble it everywhere else.
      bus.opcode = in_dec ? op : 7'($urandom);
      if (bus.mem_req && !bus.iord) begin
        bus.mem_ready = (fcnt == fw - 1);
        fcnt++;
      end else if (bus.mem_req) begin
        bus.mem_ready = (mcnt == mw - 1);
        mcnt++;
      end else begin
        bus.mem_ready = 1'($urandom_range(0, 1));
      end
      @(negedge clk);
      pcw += int'(bus.pc_write);
      irw += int'(bus.ir_write);
      rw  += int'(bus.reg_write);
      mtr |= bus.mem_to_reg;
      mask[bus.alu_op] = 1'b1;
      in_dec = bus.ir_write;
      @(posedge clk);
      #1;
    end
    bus.mem_ready = 1'b0;
    back = bus.mem_req && !bus.iord && !bus.mem_we && (bus.alu_src_b == 2'b01);
    chk({tag, "_back_to_fetch"}, 32'(back), 32'(exp_back));
    chk({tag, "_fetch_req_cycles"}, fcnt, fw);
    chk({tag, "_mem_req_cycles"}, mcnt, mw);
    chk({tag, "_pc_write"}, pcw, exp_pcw);
    chk({tag, "_ir_write"}, irw, 1);
    chk({tag, "_reg_write"}, rw, exp_rw);
    chk({tag, "_mem_to_reg"}, 32'(mtr), 32'(exp_mtr));
    chk({tag, "_alu_op_set"}, 32'(mask), 32'(exp_mask));
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    bus.mem_ready = 1'b0;
    sb.delete();
    exp_cnt = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int n, hit;
    rst_n = 1'b0;
    bus.opcode = '0;
    bus.zero = 1'b0;
    bus.mem_ready = 1'b0;
    #1;
    chk("reset_instret", 32'(bus.instret), 0);
    chk("reset_illegal", 32'(bus.illegal), 0);
    chk("reset_mem_we", 32'(bus.mem_we), 0);
    chk("reset_iord", 32'(bus.iord), 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("first_mem_req", 32'(bus.mem_req), 1);

    run_instr("add",   OP_R,      1, 0, 1'b0, 4, 1, 1, 4'b0101, 0, 1, 1);
    chk("add_instret", 32'(bus.instret), 1);
    run_instr("lh",    OP_LOAD,   3, 2, 1'b0, 8, 1, 1, 4'b0001, 1, 1, 1);
    run_instr("sh",    OP_STORE,  2, 3, 1'b0, 7, 1, 1, 4'b0001, 0, 0, 1);
    run_instr("bne_t", OP_BRANCH, 1, 0, 1'b0, 3, 1, 2, 4'b0011, 0, 0, 1);
    run_instr("bne_n", OP_BRANCH, 2, 0, 1'b1, 4, 1, 1, 4'b0011, 0, 0, 1);
    run_instr("or",    OP_R,      1, 0, 1'b0, 4, 1, 1, 4'b0101, 0, 1, 1);
    run_instr("sll",   OP_R,      2, 0, 1'b1, 5, 1, 1, 4'b0101, 0, 1, 1);
    run_instr("andi",  OP_I,      1, 0, 1'b0, 4, 1, 1, 4'b0101, 0, 1, 1);
    for (int i = 0; i < 8; i++) begin
      int f;
      f = int'($urandom_range(1, 3));
      run_instr("add_loop", OP_R, f, 0, 1'b0, f + 3, 1, 1, 4'b0101, 0, 1, 1);
    end
    chk("instret_wrap", 32'(bus.instret), 0);
    run_instr("add_post_wrap", OP_R, 1, 0, 1'b0, 4, 1, 1, 4'b0101, 0, 1, 1);

`ifdef MULTICYCLE_CTRL_ILLEGAL_TRAP_EN
    run_instr("bad", OP_BAD, 2, 0, 1'b0, 3, 0, 1, 4'b0001, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      bus.mem_ready = 1'($urandom_range(0, 1));
      bus.opcode = 7'($urandom);
      @(negedge clk);
      chk("halt_mem_req", 32'(bus.mem_req), 0);
      chk("halt_illegal", 32'(bus.illegal), 1);
      chk("halt_instret", 32'(bus.instret), 32'(exp_cnt));
      @(posedge clk);
      #1;
    end
    do_reset();
    chk("halt_reset_illegal", 32'(bus.illegal), 0);
    run_instr("add_after_halt", OP_R, 1, 0, 1'b0, 4, 1, 1, 4'b0101, 0, 1, 1);
`else
    run_instr("bad", OP_BAD, 2, 0, 1'b0, 3, 0, 1, 4'b0001, 0, 0, 1);
    chk("bad_illegal", 32'(bus.illegal), 0);
    chk("bad_instret", 32'(bus.instret), 32'(exp_cnt));
`endif

    // Store stalled in its write wait, then reset asynchronously mid-cycle.
    n = 0;
    hit = 0;
    while (hit < 2 && n < 30) begin
      bus.opcode = OP_STORE;
      bus.mem_ready = bus.mem_req && !bus.iord;
      if (bus.mem_req && bus.iord && bus.mem_we) begin
        bus.mem_ready = 1'b0;
        hit++;
      end
      n++;
      if (hit < 2) begin
        @(posedge clk);
        #1;
      end
    end
    chk("wr_wait_reached", hit, 2);
    #2;
    rst_n = 1'b0;
    sb.delete();
    exp_cnt = '0;
    #1;
    chk("mid_reset_mem_we", 32'(bus.mem_we), 0);
    chk("mid_reset_instret", 32'(bus.instret), 0);
    chk("mid_reset_iord", 32'(bus.iord), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("restart_mem_req", 32'(bus.mem_req), 1);
    chk("restart_iord", 32'(bus.iord), 0);
    run_instr("add_after_reset", OP_R, 2, 0, 1'b0, 5, 1, 1, 4'b0101, 0, 1, 1);

    @(negedge clk);
    chk("scoreboard_drained", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end

endmodule
